// File: rtl/multi_key_debouncer.sv
// multi_key_debouncer
//   N independent push-button channels. Each channel synchronises its raw pin,
//   debounces it with a consecutive-mismatch counter, normalises polarity so
//   that 1 always means "pressed", and emits single-cycle press / release /
//   long-press / auto-repeat pulses for the user logic.
module multi_key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 4194304,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int REPEAT_EN       = 1
) (
    input  logic              i_sys_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key,
    output logic [N_KEYS-1:0] o_state,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_long,
    output logic [N_KEYS-1:0] o_repeat
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    // Counter value at which one more mismatching sample flips the level.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    // Pin level that means "not pressed"; also the synchroniser reset value.
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
    localparam logic REP_ON   = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        KEY_RELEASED = 2'd0,
        KEY_PRESSED  = 2'd1,
        KEY_HELD     = 2'd2
    } key_state_e;

    logic rst_meta_q;
    logic rst_sync_q;

    // Reset synchroniser: asserts immediately, releases on a clock edge.
    // NOTE: every flop is written with <= so all registers update together at the edge;
    // blocking assignments here would let later statements see the new value.
    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        logic             key_meta_q;
        logic             key_sync_q;
        logic             key_pressed;
        logic [CNT_W-1:0] cnt_q,     cnt_d;
        logic             level_q,   level_d;
        logic             rise,      fall;
        key_state_e       fsm_q,     fsm_d;
        logic [TMR_W-1:0] timer_q,   timer_d;
        logic             press_q,   press_d;
        logic             release_q, release_d;
        logic             long_q,    long_d;
        logic             repeat_q,  repeat_d;

        // Two-flop pin synchroniser; the chain starts sampling on the first edge after reset.
        always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                key_meta_q <= IDLE_PIN;
                key_sync_q <= IDLE_PIN;
            end else begin
                key_meta_q <= i_key[g];
                key_sync_q <= key_meta_q;
            end
        end

        assign key_pressed = key_sync_q ^ IDLE_PIN;

        // Debounce: count consecutive samples disagreeing with the level, flip once the run is long enough.
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned,
        // which would otherwise infer a latch.
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            rise    = 1'b0;
            fall    = 1'b0;
            if (key_pressed == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = ~level_q;
                rise    = ~level_q;
                fall    = level_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Press/hold/repeat FSM driven by the debounced edges; a release drops any event due that cycle.
        always_comb begin
            fsm_d     = fsm_q;
            timer_d   = timer_q;
            press_d   = rise;
            release_d = fall;
            long_d    = 1'b0;
            repeat_d  = 1'b0;
            case (fsm_q)
                KEY_RELEASED: begin
                    timer_d = '0;
                    if (rise) begin
                        fsm_d = KEY_PRESSED;
                    end
                end
                KEY_PRESSED: begin
                    if (fall) begin
                        fsm_d   = KEY_RELEASED;
                        timer_d = '0;
                    end else if (timer_q == HOLD_LAST) begin
                        fsm_d    = KEY_HELD;
                        timer_d  = '0;
                        long_d   = 1'b1;
                        repeat_d = REP_ON;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                KEY_HELD: begin
                    if (fall) begin
                        fsm_d   = KEY_RELEASED;
                        timer_d = '0;
                    end else if (timer_q == REP_LAST) begin
                        timer_d  = '0;
                        repeat_d = REP_ON;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                default: begin
                    fsm_d   = KEY_RELEASED;
                    timer_d = '0;
                end
            endcase
        end

        // Channel state and registered event pulses, cleared by the synchronised reset.
        always_ff @(posedge i_sys_clk or negedge rst_sync_q) begin
            if (!rst_sync_q) begin
                cnt_q     <= '0;
                level_q   <= 1'b0;
                fsm_q     <= KEY_RELEASED;
                timer_q   <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                fsm_q     <= fsm_d;
                timer_q   <= timer_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
            end
        end

        assign o_state[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = release_q;
        assign o_long[g]    = long_q;
        assign o_repeat[g]  = repeat_q;
    end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Bench for multi_key_debouncer: table of key phases with expected pulse
// counts, timed corner-case sequences, and a random phase checked every
// cycle against a sample-history reference model.
module tb_multi_key_debouncer;

    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] keys  = '1;
    logic [N-1:0] st, pr, rl, lg, rp;
    logic [N-1:0] st2, pr2, rl2, lg2, rp2;

    always #5 clk = ~clk;

    multi_key_debouncer #(
        .N_KEYS(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(1)
    ) dut (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_key(keys),
        .o_state(st), .o_press(pr), .o_release(rl), .o_long(lg), .o_repeat(rp)
    );

    multi_key_debouncer #(
        .N_KEYS(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .REPEAT_EN(0)
    ) dut_nr (
        .i_sys_clk(clk), .i_rst_n(rst_n), .i_key(keys),
        .o_state(st2), .o_press(pr2), .o_release(rl2), .o_long(lg2), .o_repeat(rp2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pin samples since reset release, pressed-level history,
    // debounced level and the edge number of the latest press per channel.
    int           e;
    logic [N-1:0] smp[$];
    logic [N-1:0] kh[$];
    logic [N-1:0] m_st, m_pr, m_rl, m_lg, m_rp;
    int           press_at[N];
    int           c_pr, c_rl, c_lg, c_rp;

    typedef struct {
        logic [N-1:0] keys;
        int           cyc;
        logic [N-1:0] st;
        int           np;
        int           nrl;
        int           nlg;
        int           nrp;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e    = 0;
        smp.delete();
        kh.delete();
        m_st = '0; m_pr = '0; m_rl = '0; m_lg = '0; m_rp = '0;
    endtask

    // One active clock edge: the level flips once the last DEB+1 pressed-samples
    // (pin seen two edges earlier) all disagree with it; long/repeat follow from
    // the number of edges elapsed since the press.
    task automatic model_edge();
        logic [N-1:0] k;
        bit           flip;
        int           h;
        e++;
        smp.push_back(keys);
        m_pr = '0; m_rl = '0; m_lg = '0; m_rp = '0;
        if (e < 3) return;
        k = ~smp[e-3];
        kh.push_back(k);
        for (int c = 0; c < N; c++) begin
            if (kh.size() >= DEB + 1) begin
                flip = 1'b1;
                for (int j = 1; j <= DEB + 1; j++)
                    if (kh[kh.size()-j][c] == m_st[c]) flip = 1'b0;
                if (flip) begin
                    m_st[c] = ~m_st[c];
                    if (m_st[c]) begin
                        m_pr[c]     = 1'b1;
                        press_at[c] = e;
                    end else begin
                        m_rl[c] = 1'b1;
                    end
                end
            end
            if (m_st[c] && !m_pr[c]) begin
                h       = e - press_at[c];
                m_lg[c] = (h == HOLD);
                m_rp[c] = (h >= HOLD) && (((h - HOLD) % REP) == 0);
            end
        end
    endtask

    task automatic compare_cycle();
        check("outputs", {22'd0, st, pr, rl, lg, rp}, {22'd0, m_st, m_pr, m_rl, m_lg, m_rp});
        check("outputs_norep", {22'd0, st2, pr2, rl2, lg2, rp2},
              {22'd0, m_st, m_pr, m_rl, m_lg, 2'b00});
        c_pr += $countones(pr);
        c_rl += $countones(rl);
        c_lg += $countones(lg);
        c_rp += $countones(rp);
    endtask

    // Called at a negedge: drive pins, let one edge pass, compare at the next negedge.
    task automatic step(input logic [N-1:0] k);
        keys = k;
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic clear_counts();
        c_pr = 0; c_rl = 0; c_lg = 0; c_rp = 0;
    endtask

    // Steps until the chosen pulse (0 press, 1 long, 2 release, 3 repeat) shows on
    // channel ch; n is the step number it appeared on, -1 if the budget ran out.
    task automatic wait_event(input int which, input int ch, input int budget, output int n);
        logic [N-1:0] v;
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step(keys);
            v = (which == 0) ? pr : (which == 1) ? lg : (which == 2) ? rl : rp;
            if (v[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    // Called at a negedge: assert reset mid-cycle, check outputs clear without an edge.
    task automatic async_reset(input int low_cycles);
        #2 rst_n = 1'b0;
        #1 check("async_clear", {12'd0, st, pr, rl, lg, rp, st2, pr2, rl2, lg2, rp2}, 32'd0);
        model_reset();
        repeat (low_cycles) step(keys);
        rst_n = 1'b1;
    endtask

    initial begin : main
        int           n;
        logic [N-1:0] cur;
        int           run[N];

        // Pins are active low: 2'b11 = nothing pressed.
        tbl[0]  = '{2'b11, 10, 2'b00, 0, 0, 0, 0};
        tbl[1]  = '{2'b10, 30, 2'b01, 1, 0, 1, 1};  // press at 7th edge, long+repeat 20 later
        tbl[2]  = '{2'b10, 20, 2'b01, 0, 0, 0, 2};  // repeats every 8
        tbl[3]  = '{2'b11, 10, 2'b00, 0, 1, 0, 1};  // one last repeat, then release
        tbl[4]  = '{2'b11,  5, 2'b00, 0, 0, 0, 0};
        tbl[5]  = '{2'b10, 12, 2'b01, 1, 0, 0, 0};
        tbl[6]  = '{2'b11, 10, 2'b00, 0, 1, 0, 0};  // released before the hold time
        tbl[7]  = '{2'b10,  4, 2'b00, 0, 0, 0, 0};  // one sample too short
        tbl[8]  = '{2'b11,  8, 2'b00, 0, 0, 0, 0};
        tbl[9]  = '{2'b10,  5, 2'b00, 0, 0, 0, 0};  // shortest accepted press
        tbl[10] = '{2'b11, 12, 2'b00, 1, 1, 0, 0};
        tbl[11] = '{2'b10,  3, 2'b00, 0, 0, 0, 0};  // key1 follows 3 cycles later
        tbl[12] = '{2'b00, 30, 2'b11, 2, 0, 2, 2};
        tbl[13] = '{2'b11, 10, 2'b00, 0, 2, 0, 2};
        tbl[14] = '{2'b11,  5, 2'b00, 0, 0, 0, 0};

        model_reset();
        clear_counts();
        repeat (3) step(2'b11);
        check("reset_state", {22'd0, st, pr, rl, lg, rp}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            clear_counts();
            repeat (tbl[i].cyc) step(tbl[i].keys);
            check($sformatf("tbl%0d_state", i), {30'd0, st}, {30'd0, tbl[i].st});
            check($sformatf("tbl%0d_press", i), c_pr, tbl[i].np);
            check($sformatf("tbl%0d_release", i), c_rl, tbl[i].nrl);
            check($sformatf("tbl%0d_long", i), c_lg, tbl[i].nlg);
            check($sformatf("tbl%0d_repeat", i), c_rp, tbl[i].nrp);
        end

        // Clean press timing: press 6 edges after the first low sample, long 20
        // edges after press, next repeat 8 later, release 6 edges after the pin rises.
        keys = 2'b10;
        wait_event(0, 0, 20, n);  check("press_latency", n, 7);
        wait_event(1, 0, 40, n);  check("long_latency", n, HOLD);
        wait_event(3, 0, 20, n);  check("repeat_period", n, REP);
        keys = 2'b11;
        wait_event(2, 0, 20, n);  check("release_latency", n, 7);
        repeat (8) step(2'b11);

        // Bounce: 3 low / 1 high never settles; a steady low then presses on time.
        clear_counts();
        repeat (10) begin
            repeat (3) step(2'b10);
            step(2'b11);
        end
        check("bounce_no_press", c_pr, 0);
        check("bounce_state", {30'd0, st}, 32'd0);
        keys = 2'b10;
        wait_event(0, 0, 20, n);  check("bounce_settle", n, 7);
        repeat (12) step(2'b11);

        // A key1 glitch in the middle of key0's debounce leaves key0's timing intact.
        step(2'b10);
        step(2'b10);
        step(2'b00);
        step(2'b00);
        keys = 2'b10;
        wait_event(0, 0, 20, n);  check("indep_press", n, 3);
        check("indep_key1_idle", {31'd0, st[1]}, 32'd0);
        repeat (12) step(2'b11);

        // Reset while HELD with the key still down: no release, fresh press.
        keys = 2'b10;
        wait_event(0, 0, 20, n);  check("held_press", n, 7);
        repeat (25) step(2'b10);
        async_reset(3);
        clear_counts();
        wait_event(0, 0, 20, n);  check("post_reset_press", n, 7);
        repeat (5) step(2'b10);
        check("post_reset_no_release", c_rl, 0);
        repeat (12) step(2'b11);

        // Random pin activity on both channels, with one reset part way through.
        cur = 2'b11;
        run = '{0, 0};
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (run[c] == 0) begin
                    cur[c] = ~cur[c];
                    run[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                          : int'($urandom_range(6, 70));
                end
                run[c]--;
            end
            if (i == 1500) async_reset(2);
            step(cur);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
